fifo_write_arbiter: RTL and testbench

- Shares the single write port of one `fifo` instance between NumRequesters independent producers.
- Uses round-robin arbitration with an optional bounded burst lock, so one producer can push several consecutive entries without interleaving.
- Sits directly in front of `fifo`: it drives `write_req_i`/`data_i` and consumes `write_valid_o`.
- The read side of the fifo is untouched.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  // Index width for an N-entry selection; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) begin
      w = unsigned'($clog2(n));
    end
    return w;
  endfunction

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority search: first asserted request at or after start_i, wrapping.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic            found_o,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  // One spare bit so start + offset never overflows before the wrap.
  logic [IdxW:0]   cand;
  logic [IdxW-1:0] cand_idx;

  // Walk candidates start, start+1, ... mod N and keep the first requester.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, start_i} + (IdxW + 1)'(i);
      if (cand >= (IdxW + 1)'(N)) begin
        cand = cand - (IdxW + 1)'(N);
      end
      cand_idx = cand[IdxW-1:0];
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    gnt_o = found_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one fifo write port among several producers: round-robin with bounded burst lock.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned Width         = 8,
  parameter int unsigned MaxBurst      = 4,
  localparam int unsigned IdxW         = idx_width(NumRequesters)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumRequesters-1:0]         req_i,
  input  logic [NumRequesters-1:0]         lock_i,
  input  logic [NumRequesters*Width-1:0]   data_i,
  output logic [NumRequesters-1:0]         gnt_o,
  input  logic                             fifo_write_valid_i,
  output logic                             fifo_write_req_o,
  output logic [Width-1:0]                 fifo_data_o,
  output logic [IdxW-1:0]                  owner_o,
  output logic                             locked_o
);

  localparam int unsigned  CntW     = idx_width(MaxBurst + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumRequesters - 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(MaxBurst);
  // A burst of one is indistinguishable from a plain transfer, so locking is disabled.
  localparam bit           BurstEn  = (MaxBurst > 1);

  arb_state_e                 state_q, state_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;
  logic [IdxW-1:0]            owner_q, owner_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [CntW-1:0]            cnt_inc;
  logic                       release_c;

  logic                       pick_found;
  logic [NumRequesters-1:0]   pick_gnt;
  logic [IdxW-1:0]            pick_idx;

  logic [NumRequesters-1:0]   owner_onehot;
  logic [NumRequesters-1:0]   gnt_c;
  logic                       xfer_c;
  logic [Width-1:0]           data_c;

  // Next index with wrap-around at NumRequesters.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] nxt;
    nxt = idx + IdxW'(1);
    if (idx == LastIdx) begin
      nxt = '0;
    end
    return nxt;
  endfunction

  rr_priority_picker #(
    .N (NumRequesters)
  ) u_picker (
    .req_i   (req_i),
    .start_i (ptr_q),
    .found_o (pick_found),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  assign owner_onehot = NumRequesters'(1) << owner_q;

  // Zero-latency grant; suppressed while full or in reset.
  always_comb begin
    gnt_c = '0;
    if (!rst_i && fifo_write_valid_i) begin
      if (state_q == ARB_IDLE) begin
        if (pick_found) begin
          gnt_c = pick_gnt;
        end
      end else if (req_i[owner_q]) begin
        gnt_c = owner_onehot;
      end
    end
    xfer_c = |gnt_c;
  end

  // One-hot data mux: granted producer's slice, zero when idle.
  always_comb begin
    data_c = '0;
    for (int unsigned k = 0; k < NumRequesters; k++) begin
      if (gnt_c[k]) begin
        data_c = data_c | data_i[k*Width +: Width];
      end
    end
  end

  // Arbitration state machine: pointer advance, burst entry, burst release.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
    cnt_inc   = cnt_q + CntW'(1);
    unique case (state_q)
      ARB_IDLE: begin
        if (xfer_c) begin
          owner_d = pick_idx;
          if (BurstEn && lock_i[pick_idx]) begin
            state_d = ARB_LOCKED;
            cnt_d   = CntW'(1);
          end else begin
            ptr_d = wrap_inc(pick_idx);
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer_c) begin
          cnt_d     = cnt_inc;
          release_c = (cnt_inc >= BurstMax) || !lock_i[owner_q];
        end else if (fifo_write_valid_i && !req_i[owner_q]) begin
          // Owner walked away while the fifo had room.
          release_c = 1'b1;
        end
        if (release_c) begin
          state_d = ARB_IDLE;
          ptr_d   = wrap_inc(owner_q);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o            = gnt_c;
  assign fifo_write_req_o = xfer_c;
  assign fifo_data_o      = data_c;
  assign owner_o          = owner_q;
  assign locked_o         = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-based fifo and producers, rule-level arbiter model.
module tb_fifo_write_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MaxB     = 4;
  localparam int FifoSize = 10;

  typedef logic [7:0] byte_q_t[$];

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           fifo_wv;
  logic           wr;
  logic [W-1:0]   fdata;
  logic [1:0]     owner;
  logic           locked;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NumRequesters (N),
    .Width         (W),
    .MaxBurst      (MaxB)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_i              (req),
    .lock_i             (lock),
    .data_i             (data),
    .gnt_o              (gnt),
    .fifo_write_valid_i (fifo_wv),
    .fifo_write_req_o   (wr),
    .fifo_data_o        (fdata),
    .owner_o            (owner),
    .locked_o           (locked)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model of arbiter rules
  int m_ptr    = 0;
  int m_owner  = 0;
  int m_cnt    = 0;
  bit m_locked = 1'b0;
  int exp_win  = -1;

  // Per-cycle snapshot taken on the falling edge
  logic [N-1:0] s_req, s_lock, s_gnt;
  logic         s_wv, s_rst, s_wr, s_pop;
  logic [W-1:0] s_data;

  byte_q_t      prod_q[N];
  logic [7:0]   fifo_q[$];
  logic [7:0]   wr_log[$];
  logic [7:0]   exp_log[$];
  bit [N-1:0]   lock_en = '0;
  logic         pop;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Falling-edge compare of DUT outputs against the model
  always @(negedge clk) begin : compare_proc
    int           w;
    int           k;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    s_req  = req;
    s_lock = lock;
    s_wv   = fifo_wv;
    s_rst  = rst;
    s_gnt  = gnt;
    s_wr   = wr;
    s_data = fdata;
    s_pop  = pop;
    w = -1;
    if (!rst && fifo_wv) begin
      if (m_locked) begin
        if (req[m_owner]) w = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (w < 0 && req[k]) w = k;
        end
      end
    end
    exp_win = w;
    eg = '0;
    ed = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ed    = data[w*W +: W];
    end
    if (chk_en) begin
      cmp("gnt", 32'(gnt), 32'(eg));
      cmp("write_req", 32'(wr), 32'(w >= 0));
      cmp("fifo_data", 32'(fdata), 32'(ed));
      cmp("owner", 32'(owner), 32'(m_owner));
      cmp("locked", 32'(locked), 32'(m_locked));
    end
  end

  task automatic drive_prod();
    for (int k = 0; k < N; k++) begin
      if (prod_q[k].size() > 0) begin
        req[k]          = 1'b1;
        data[k*W +: W]  = prod_q[k][0];
      end else begin
        req[k]          = 1'b0;
        data[k*W +: W]  = '0;
      end
      lock[k] = lock_en[k] & req[k];
    end
  endtask

  task automatic model_release();
    m_locked = 1'b0;
    m_ptr    = (m_owner + 1) % N;
    m_cnt    = 0;
  endtask

  // Advance one clock: fifo, producers and model react to the sampled cycle
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (s_wr === 1'b1) begin
      fifo_q.push_back(s_data);
      wr_log.push_back(s_data);
      cmp("fifo_depth_ok", 32'(fifo_q.size() <= FifoSize), 32'd1);
    end
    fifo_wv = (fifo_q.size() < FifoSize);
    for (int k = 0; k < N; k++) begin
      if (s_gnt[k] && s_req[k] && prod_q[k].size() > 0) void'(prod_q[k].pop_front());
    end
    if (s_rst) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    end else if (exp_win >= 0) begin
      m_owner = exp_win;
      if (!m_locked) begin
        if (s_lock[exp_win] && MaxB > 1) begin
          m_locked = 1'b1;
          m_cnt    = 1;
        end else begin
          m_ptr = (exp_win + 1) % N;
        end
      end else begin
        m_cnt++;
        if (m_cnt == MaxB || !s_lock[exp_win]) model_release();
      end
    end else if (m_locked && s_wv && !s_req[m_owner]) begin
      model_release();
    end
    drive_prod();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    pop = 1'b1;
    for (int i = 0; i < 30 && fifo_q.size() > 0; i++) tick();
    pop = 1'b0;
    cmp("drain_done", 32'(fifo_q.size()), 32'd0);
  endtask

  task automatic check_log(input string name);
    cmp({name, "_len"}, 32'(wr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < wr_log.size()) cmp(name, 32'(wr_log[i]), 32'(exp_log[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; data = '0; pop = 1'b0; fifo_wv = 1'b1;

    // Reset for 100 cycles, then idle
    tick(); tick();
    chk_en = 1'b1;
    repeat (98) tick();
    rst = 1'b0;
    tick();
    settle();
    cmp("idle_gnt", 32'(gnt), 32'd0);
    cmp("idle_wr", 32'(wr), 32'd0);
    cmp("idle_owner", 32'(owner), 32'd0);
    cmp("idle_locked", 32'(locked), 32'd0);

    // All four request, no lock: strict rotation from 0
    wr_log.delete();
    for (int k = 0; k < N; k++) begin
      prod_q[k].push_back(8'(8'h10 + k));
      prod_q[k].push_back(8'(8'h10 + k));
    end
    drive_prod();
    repeat (8) tick();
    exp_log = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
    check_log("rr_order");
    drain();

    // Producer 2 locked burst vs producer 0
    wr_log.delete();
    lock_en = 4'b0100;
    for (int i = 0; i < 6; i++) prod_q[2].push_back(8'(8'hA0 + i));
    drive_prod();
    tick();
    settle();
    cmp("burst_locked", 32'(locked), 32'd1);
    cmp("burst_owner", 32'(owner), 32'd2);
    prod_q[0].push_back(8'h00);
    drive_prod();
    repeat (8) tick();
    exp_log = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5};
    check_log("burst_order");
    settle();
    cmp("burst_released", 32'(locked), 32'd0);
    lock_en = '0;
    drain();

    // Fill fifo with producer 1, then single pop
    wr_log.delete();
    for (int i = 0; i < 12; i++) prod_q[1].push_back(8'(8'h40 + i));
    drive_prod();
    repeat (12) tick();
    settle();
    cmp("fill_count", 32'(fifo_q.size()), 32'd10);
    cmp("full_gnt", 32'(gnt), 32'd0);
    cmp("full_wr", 32'(wr), 32'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    settle();
    cmp("refill_gnt", 32'(gnt), 32'b0010);
    cmp("refill_data", 32'(fdata), 32'h4A);
    tick();
    settle();
    cmp("refull_count", 32'(fifo_q.size()), 32'd10);
    cmp("refull_gnt", 32'(gnt), 32'd0);
    prod_q[1].delete();
    drive_prod();
    pop = 1'b1;
    tick(); tick();
    pop = 1'b0;
    cmp("partial_count", 32'(fifo_q.size()), 32'd8);

    // Locked burst of producer 0 stalled by full fifo, producer 3 waiting
    wr_log.delete();
    lock_en = 4'b0001;
    for (int i = 0; i < 4; i++) prod_q[0].push_back(8'(8'hC0 + i));
    drive_prod();
    tick();
    prod_q[3].push_back(8'h3F);
    drive_prod();
    tick();
    settle();
    cmp("stall_locked", 32'(locked), 32'd1);
    cmp("stall_gnt", 32'(gnt), 32'd0);
    cmp("stall_owner", 32'(owner), 32'd0);
    tick();
    settle();
    cmp("stall_hold", 32'(locked), 32'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    settle();
    cmp("stall_resume_gnt", 32'(gnt), 32'b0001);
    cmp("stall_resume_locked", 32'(locked), 32'd1);
    cmp("stall_resume_data", 32'(fdata), 32'hC2);
    tick();
    settle();
    cmp("stall_p3_blocked", 32'(gnt), 32'd0);
    pop = 1'b1;
    repeat (4) tick();
    pop = 1'b0;
    exp_log = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h3F};
    check_log("stall_order");
    lock_en = '0;
    drain();

    // Reset mid-burst at count 2
    wr_log.delete();
    lock_en = 4'b0100;
    for (int i = 0; i < 5; i++) prod_q[2].push_back(8'(8'hB0 + i));
    drive_prod();
    tick(); tick();
    settle();
    cmp("pre_rst_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    settle();
    cmp("rst_gnt", 32'(gnt), 32'd0);
    cmp("rst_wr", 32'(wr), 32'd0);
    cmp("rst_data", 32'(fdata), 32'd0);
    tick();
    settle();
    cmp("post_rst_locked", 32'(locked), 32'd0);
    cmp("post_rst_owner", 32'(owner), 32'd0);
    cmp("post_rst_gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    lock_en = '0;
    prod_q[0].push_back(8'hD0);
    prod_q[1].push_back(8'hD1);
    prod_q[3].push_back(8'hD3);
    drive_prod();
    settle();
    cmp("after_rst_first", 32'(gnt), 32'b0001);
    cmp("after_rst_data", 32'(fdata), 32'hD0);
    repeat (6) tick();
    exp_log = '{8'hB0, 8'hB1, 8'hD0, 8'hD1, 8'hB2, 8'hD3, 8'hB3, 8'hB4};
    check_log("rst_order");
    drain();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
